// File: rtl/division_pkg.sv
// Shared types and constants for the 8-bit divider family and its result checker.
// Result word layout: P[15:8] = quotient, P[7:0] = remainder.
package division_pkg;

   localparam int          DIV_W              = 8;
   localparam logic [15:0] DIV_BY_ZERO_RESULT = 16'hFFFF;

   typedef struct packed {
      logic [DIV_W-1:0] a;
      logic [DIV_W-1:0] b;
   } div_operands_t;

   function automatic logic [DIV_W-1:0] res_q(input logic [2*DIV_W-1:0] p);
      return p[2*DIV_W-1:DIV_W];
   endfunction

   function automatic logic [DIV_W-1:0] res_r(input logic [2*DIV_W-1:0] p);
      return p[DIV_W-1:0];
   endfunction

endpackage

// File: rtl/division_op_fifo.sv
// Synchronous in-order FIFO with occupancy count. A pop on a non-empty FIFO frees
// its slot in the same cycle, so a concurrent push is accepted even when full.
module division_op_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [WIDTH-1:0]           wdata_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: only slots between the pointers are ever read.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/division_checker.sv
// Reverse-checks divider results against the operands issued for them, in issue order,
// with a fixed two-cycle check pipeline and saturating pass/fail statistics.
module division_checker
   import division_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [7:0]               A,
   input  logic [7:0]               B,
   input  logic                     valid,
   input  logic [15:0]              P,
   output logic                     chk_valid,
   output logic                     chk_ok,
   output logic [7:0]               chk_a,
   output logic [7:0]               chk_b,
   output logic [15:0]              chk_p,
   output logic [CNT_W-1:0]         n_checked,
   output logic [CNT_W-1:0]         n_errors,
   output logic [$clog2(DEPTH):0]   pending,
   output logic                     fifo_overflow,
   output logic                     orphan_result
);

   // start and valid are single-cycle strobes with no backpressure: every cycle a
   // strobe is high is exactly one transaction, and nothing here can stall the divider.

   logic [2*DIV_W-1:0] fifo_wdata, fifo_rdata;
   div_operands_t      head;
   logic               fifo_full, fifo_empty;
   logic               push_en, pop_en;

   assign fifo_wdata = {A, B};
   assign head       = div_operands_t'(fifo_rdata);
   assign pop_en     = valid && !fifo_empty;
   assign push_en    = start && (!fifo_full || pop_en);

   division_op_fifo #(
      .WIDTH (2*DIV_W),
      .DEPTH (DEPTH)
   ) u_op_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push_en),
      .pop_i   (pop_en),
      .wdata_i (fifo_wdata),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (pending)
   );

   // Stage 1: operands, result and the Q*B product.
   logic               s1_valid_q;
   logic [DIV_W-1:0]   s1_a_q, s1_b_q;
   logic [2*DIV_W-1:0] s1_p_q, s1_prod_q, prod_d;

   assign prod_d = {{DIV_W{1'b0}}, res_q(P)} * {{DIV_W{1'b0}}, head.b};

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_p_q     <= '0;
         s1_prod_q  <= '0;
      end else begin
         s1_valid_q <= pop_en;
         if (pop_en) begin
            s1_a_q    <= head.a;
            s1_b_q    <= head.b;
            s1_p_q    <= P;
            s1_prod_q <= prod_d;
         end
      end
   end

   // Stage 2: the check itself, done in 17 bits so Q*B + R cannot wrap into a false pass.
   logic [2*DIV_W:0] recon;
   logic             ok_d;

   always_comb begin
      recon = {1'b0, s1_prod_q} + {{(DIV_W+1){1'b0}}, res_r(s1_p_q)};
      ok_d  = 1'b0;
      if (s1_b_q == '0) ok_d = (s1_p_q == DIV_BY_ZERO_RESULT);
      else              ok_d = (recon == {{(DIV_W+1){1'b0}}, s1_a_q}) && (res_r(s1_p_q) < s1_b_q);
   end

   logic               chk_valid_q, chk_ok_q;
   logic [DIV_W-1:0]   chk_a_q, chk_b_q;
   logic [2*DIV_W-1:0] chk_p_q;
   logic [CNT_W-1:0]   n_checked_q, n_errors_q, n_checked_d, n_errors_d;
   logic               overflow_q, orphan_q;

   always_comb begin
      n_checked_d = n_checked_q;
      n_errors_d  = n_errors_q;
      if (s1_valid_q && (n_checked_q != '1))       n_checked_d = n_checked_q + CNT_W'(1);
      if (s1_valid_q && !ok_d && (n_errors_q != '1)) n_errors_d = n_errors_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         chk_valid_q <= 1'b0;
         chk_ok_q    <= 1'b0;
         chk_a_q     <= '0;
         chk_b_q     <= '0;
         chk_p_q     <= '0;
         n_checked_q <= '0;
         n_errors_q  <= '0;
         overflow_q  <= 1'b0;
         orphan_q    <= 1'b0;
      end else begin
         chk_valid_q <= s1_valid_q;
         chk_ok_q    <= s1_valid_q && ok_d;
         if (s1_valid_q) begin
            chk_a_q <= s1_a_q;
            chk_b_q <= s1_b_q;
            chk_p_q <= s1_p_q;
         end
         n_checked_q <= n_checked_d;
         n_errors_q  <= n_errors_d;
         // Empty-FIFO valid is judged on the pre-push state, so it is an orphan even with start.
         if (start && fifo_full && !pop_en) overflow_q <= 1'b1;
         if (valid && fifo_empty)           orphan_q   <= 1'b1;
      end
   end

   assign chk_valid     = chk_valid_q;
   assign chk_ok        = chk_ok_q;
   assign chk_a         = chk_a_q;
   assign chk_b         = chk_b_q;
   assign chk_p         = chk_p_q;
   assign n_checked     = n_checked_q;
   assign n_errors      = n_errors_q;
   assign fifo_overflow = overflow_q;
   assign orphan_result = orphan_q;

endmodule

// File: tb/tb_division_checker.sv
// Self-checking bench for division_checker: an operand model predicts pops, a scoreboard
// queue holds expected checks, and a negedge monitor compares every chk_valid pulse.
module tb_division_checker;

   localparam int DEPTH = 8;
   localparam int CNT_W = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  A = '0;
   logic [7:0]  B = '0;
   logic        valid = 1'b0;
   logic [15:0] P = '0;
   logic        chk_valid, chk_ok;
   logic [7:0]  chk_a, chk_b;
   logic [15:0] chk_p;
   logic [CNT_W-1:0] n_checked, n_errors;
   logic [3:0]  pending;
   logic        fifo_overflow, orphan_result;

   division_checker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .start(start), .A(A), .B(B), .valid(valid), .P(P),
      .chk_valid(chk_valid), .chk_ok(chk_ok), .chk_a(chk_a), .chk_b(chk_b), .chk_p(chk_p),
      .n_checked(n_checked), .n_errors(n_errors), .pending(pending),
      .fifo_overflow(fifo_overflow), .orphan_result(orphan_result)
   );

   // clock / reset
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] p;
      logic        ok;
      int          due;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] op_q[$];
   int          m_checked, m_errors;
   logic        m_overflow, m_orphan;
   int          total = 0;
   int          bad = 0;

   function automatic logic ref_ok(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
      int q, r;
      q = int'(p[15:8]);
      r = int'(p[7:0]);
      if (b == 8'd0) return (p == 16'hFFFF);
      return ((q * int'(b) + r) == int'(a)) && (r < int'(b));
   endfunction

   // driver: one cycle of stimulus, with the operand model updated for that cycle
   task automatic step(input logic st, input logic [7:0] a, input logic [7:0] b,
                       input logic vl, input logic [15:0] p);
      int   pre;
      logic popped;
      logic [15:0] op;
      exp_t e;
      start = st; A = a; B = b; valid = vl; P = p;
      pre = op_q.size();
      popped = 1'b0;
      if (vl) begin
         if (pre > 0) begin
            op = op_q.pop_front();
            e.a = op[15:8]; e.b = op[7:0]; e.p = p;
            e.ok = ref_ok(op[15:8], op[7:0], p);
            e.due = cyc + 2;
            exp_q.push_back(e);
            m_checked++;
            if (!e.ok) m_errors++;
            popped = 1'b1;
         end else m_orphan = 1'b1;
      end
      if (st) begin
         if (pre < DEPTH || popped) op_q.push_back({a, b});
         else m_overflow = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0; valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'd0, 8'd0, 1'b0, 16'd0);
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1; start = 1'b0; valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      reset = 1'b0;
      op_q.delete();
      exp_q.delete();
      m_checked = 0; m_errors = 0; m_overflow = 1'b0; m_orphan = 1'b0;
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (!reset) begin
         total++;
         if (chk_valid) begin
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_chk_valid: got a=%0d b=%0d p=%h ok=%0b, expected no pulse",
                        chk_a, chk_b, chk_p, chk_ok);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if ({chk_a, chk_b, chk_p, chk_ok} !== {e.a, e.b, e.p, e.ok} || cyc != e.due) begin
                  bad++;
                  $display("FAIL chk_result: got a=%0d b=%0d p=%h ok=%0b cyc=%0d, expected a=%0d b=%0d p=%h ok=%0b cyc=%0d",
                           chk_a, chk_b, chk_p, chk_ok, cyc, e.a, e.b, e.p, e.ok, e.due);
               end
            end
         end else if (chk_ok !== 1'b0 || (exp_q.size() > 0 && cyc > exp_q[0].due)) begin
            bad++;
            $display("FAIL chk_idle: got chk_ok=%0b cyc=%0d, expected chk_ok=0 and no overdue check", chk_ok, cyc);
         end
      end
   end

   task automatic test_reset();
      do_reset(3);
      total++;
      if ({chk_valid, chk_ok, chk_a, chk_b, chk_p, n_checked, n_errors, pending,
           fifo_overflow, orphan_result} !== '0) begin
         bad++;
         $display("FAIL reset_state: got v=%0b ok=%0b a=%0d b=%0d p=%h nc=%0d ne=%0d pend=%0d ovf=%0b orph=%0b, expected all 0",
                  chk_valid, chk_ok, chk_a, chk_b, chk_p, n_checked, n_errors, pending, fifo_overflow, orphan_result);
      end
   endtask

   task automatic test_single();
      step(1'b1, 8'd100, 8'd10, 1'b0, 16'd0);
      total++;
      if (pending !== 4'd1) begin bad++; $display("FAIL single_pending_up: got %0d expected 1", pending); end
      idle(2);
      step(1'b0, 8'd0, 8'd0, 1'b1, {8'd10, 8'd0});
      total++;
      if (pending !== 4'd0) begin bad++; $display("FAIL single_pending_down: got %0d expected 0", pending); end
      idle(3);
      total++;
      if (n_checked !== CNT_W'(1) || n_errors !== CNT_W'(0)) begin
         bad++; $display("FAIL single_counters: got nc=%0d ne=%0d expected nc=1 ne=0", n_checked, n_errors);
      end
   endtask

   task automatic test_back_to_back();
      int ai, bi;
      for (int i = 0; i < 13; i++) begin
         logic [15:0] p;
         ai = 150 + 5 * (i - 3);
         bi = 10 + (i - 3);
         p = (i >= 3) ? {8'(ai / bi), 8'(ai % bi)} : 16'd0;
         step(i < 10, 8'(150 + 5 * i), 8'(10 + i), i >= 3, p);
      end
      idle(3);
      total++;
      if (n_checked !== CNT_W'(m_checked) || n_errors !== CNT_W'(m_errors) || pending !== 4'd0) begin
         bad++;
         $display("FAIL b2b_counters: got nc=%0d ne=%0d pend=%0d expected nc=%0d ne=%0d pend=0",
                  n_checked, n_errors, pending, m_checked, m_errors);
      end
   endtask

   task automatic test_corrupt();
      step(1'b1, 8'd77, 8'd7, 1'b0, 16'd0);
      step(1'b0, 8'd0, 8'd0, 1'b1, {8'd11, 8'd1});
      step(1'b1, 8'd255, 8'd16, 1'b0, 16'd0);
      step(1'b0, 8'd0, 8'd0, 1'b1, {8'd15, 8'd16});
      idle(3);
      total++;
      if (n_errors !== CNT_W'(m_errors) || n_checked !== CNT_W'(m_checked)) begin
         bad++; $display("FAIL corrupt_counters: got nc=%0d ne=%0d expected nc=%0d ne=%0d",
                         n_checked, n_errors, m_checked, m_errors);
      end
   endtask

   task automatic test_div_zero();
      step(1'b1, 8'd100, 8'd0, 1'b0, 16'd0);
      step(1'b0, 8'd0, 8'd0, 1'b1, 16'hFFFF);
      step(1'b1, 8'd100, 8'd0, 1'b1, 16'h00FF);
      step(1'b0, 8'd0, 8'd0, 1'b1, 16'h00FF);
      idle(3);
      total++;
      if (n_errors !== CNT_W'(m_errors) || n_checked !== CNT_W'(m_checked)) begin
         bad++; $display("FAIL divzero_counters: got nc=%0d ne=%0d expected nc=%0d ne=%0d",
                         n_checked, n_errors, m_checked, m_errors);
      end
   endtask

   task automatic test_boundaries();
      do_reset(1);
      for (int i = 0; i < DEPTH; i++)
         step(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)), 1'b0, 16'd0);
      total++;
      if (pending !== 4'(DEPTH) || fifo_overflow !== 1'b0) begin
         bad++; $display("FAIL fill_exact: got pend=%0d ovf=%0b expected pend=%0d ovf=0", pending, fifo_overflow, DEPTH);
      end
      step(1'b1, 8'd200, 8'd9, 1'b1, {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))});
      total++;
      if (pending !== 4'(DEPTH) || fifo_overflow !== 1'b0) begin
         bad++; $display("FAIL full_push_pop: got pend=%0d ovf=%0b expected pend=%0d ovf=0", pending, fifo_overflow, DEPTH);
      end
      step(1'b1, 8'd1, 8'd1, 1'b0, 16'd0);
      total++;
      if (pending !== 4'(DEPTH) || fifo_overflow !== 1'b1) begin
         bad++; $display("FAIL overflow: got pend=%0d ovf=%0b expected pend=%0d ovf=1", pending, fifo_overflow, DEPTH);
      end
      while (op_q.size() > 0) begin
         logic [15:0] op;
         op = op_q[0];
         step(1'b0, 8'd0, 8'd0, 1'b1, {8'(op[15:8] / op[7:0]), 8'(op[15:8] % op[7:0])});
      end
      idle(3);
      step(1'b0, 8'd0, 8'd0, 1'b1, 16'h1234);
      idle(2);
      total++;
      if (orphan_result !== 1'b1 || n_checked !== CNT_W'(m_checked) || pending !== 4'd0) begin
         bad++; $display("FAIL orphan: got orph=%0b nc=%0d pend=%0d expected orph=1 nc=%0d pend=0",
                         orphan_result, n_checked, pending, m_checked);
      end
      step(1'b1, 8'd50, 8'd5, 1'b1, 16'h5555);
      total++;
      if (pending !== 4'd1 || n_checked !== CNT_W'(m_checked)) begin
         bad++; $display("FAIL empty_push_pop: got pend=%0d nc=%0d expected pend=1 nc=%0d", pending, n_checked, m_checked);
      end
      step(1'b0, 8'd0, 8'd0, 1'b1, {8'd10, 8'd0});
      idle(3);
      total++;
      if (n_checked !== CNT_W'(m_checked) || n_errors !== CNT_W'(m_errors) || fifo_overflow !== m_overflow) begin
         bad++; $display("FAIL boundary_counters: got nc=%0d ne=%0d ovf=%0b expected nc=%0d ne=%0d ovf=%0b",
                         n_checked, n_errors, fifo_overflow, m_checked, m_errors, m_overflow);
      end
   endtask

   task automatic test_reset_midflight();
      step(1'b1, 8'd90, 8'd9, 1'b0, 16'd0);
      step(1'b1, 8'd91, 8'd9, 1'b0, 16'd0);
      step(1'b1, 8'd92, 8'd9, 1'b0, 16'd0);
      step(1'b0, 8'd0, 8'd0, 1'b1, {8'd10, 8'd0});
      do_reset(1);
      idle(2);
      total++;
      if ({chk_valid, chk_ok, chk_a, chk_b, chk_p, n_checked, n_errors, pending,
           fifo_overflow, orphan_result} !== '0) begin
         bad++;
         $display("FAIL midflight_reset: got v=%0b a=%0d b=%0d p=%h nc=%0d ne=%0d pend=%0d ovf=%0b orph=%0b, expected all 0",
                  chk_valid, chk_a, chk_b, chk_p, n_checked, n_errors, pending, fifo_overflow, orphan_result);
      end
      step(1'b1, 8'd144, 8'd12, 1'b0, 16'd0);
      step(1'b0, 8'd0, 8'd0, 1'b1, {8'd12, 8'd0});
      idle(3);
      total++;
      if (n_checked !== CNT_W'(1) || n_errors !== CNT_W'(0)) begin
         bad++; $display("FAIL resume: got nc=%0d ne=%0d expected nc=1 ne=0", n_checked, n_errors);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not complete within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      m_checked = 0; m_errors = 0; m_overflow = 1'b0; m_orphan = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_corrupt();
      test_div_zero();
      test_boundaries();
      test_reset_midflight();
      total++;
      if (exp_q.size() != 0) begin
         bad++; $display("FAIL scoreboard_drain: got %0d outstanding expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
